// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the CPU clock run/halt/step controller.
package clk_ctrl_pkg;

    localparam int unsigned DIV_W        = 16;
    localparam int unsigned DEFAULT_HALF = 10;

    typedef enum logic [1:0] {
        HALT   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } run_state_t;

endpackage

// File: rtl/step_edge_det.sv
// Rising-edge detector for the debounced single-step button level.
module step_edge_det (
    input  logic clk_in,
    input  logic rst,
    input  logic step_req,
    output logic step_pulse
);

    logic step_prev;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            step_prev <= 1'b0;
        end else begin
            step_prev <= step_req;
        end
    end

    assign step_pulse = step_req & ~step_prev;

endmodule

// File: rtl/clk_run_ctrl.sv
// Run/halt/single-step controller producing a divided CPU clock and a
// one-cycle clock enable, with glitch-free runtime divisor changes.
module clk_run_ctrl #(
    parameter int unsigned DIV_W        = clk_ctrl_pkg::DIV_W,
    parameter int unsigned DEFAULT_HALF = clk_ctrl_pkg::DEFAULT_HALF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run_en,
    input  logic             step_req,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic             clk_out,
    output logic             cpu_ce,
    output logic             halted
);

    import clk_ctrl_pkg::*;

    run_state_t       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             clk_out_d, cpu_ce_d, div_ack_d, halted_d;

    logic             step_pulse;
    logic             phase_last;
    logic             at_boundary;
    logic             apply_pend;
    logic [DIV_W-1:0] div_clamped;

    step_edge_det u_step_edge_det (
        .clk_in     (clk_in),
        .rst        (rst),
        .step_req   (step_req),
        .step_pulse (step_pulse)
    );

    assign div_clamped = (div_val == '0) ? DIV_W'(1) : div_val;
    assign phase_last  = (cnt_q == half_q - DIV_W'(1));
    assign at_boundary = (state_q != HALT) && !clk_out && phase_last;
    // half only changes at a boundary or while halted, so no phase is cut short
    assign apply_pend  = pend_valid_q && (at_boundary || state_q == HALT);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        half_d       = half_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        clk_out_d    = clk_out;
        cpu_ce_d     = 1'b0;
        div_ack_d    = 1'b0;

        if (apply_pend) begin
            half_d       = pend_q;
            pend_valid_d = 1'b0;
            div_ack_d    = 1'b1;
        end
        if (div_load) begin
            pend_d       = div_clamped;
            pend_valid_d = 1'b1;
        end

        case (state_q)
            HALT: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                if (run_en || step_pulse) begin
                    state_d   = run_en ? RUN : FINISH;
                    clk_out_d = 1'b1;
                    cpu_ce_d  = 1'b1;
                end
            end
            RUN, FINISH: begin
                // RUN with run_en low behaves exactly like FINISH
                if (at_boundary) begin
                    cnt_d = '0;
                    if (run_en) begin
                        state_d   = RUN;
                        clk_out_d = 1'b1;
                        cpu_ce_d  = 1'b1;
                    end else begin
                        state_d   = HALT;
                        clk_out_d = 1'b0;
                    end
                end else begin
                    state_d = run_en ? RUN : FINISH;
                    if (phase_last) begin
                        cnt_d     = '0;
                        clk_out_d = ~clk_out;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
            end
            default: begin
                state_d   = HALT;
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase

        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= HALT;
            cnt_q        <= '0;
            half_q       <= DIV_W'(DEFAULT_HALF);
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            clk_out      <= 1'b0;
            cpu_ce       <= 1'b0;
            div_ack      <= 1'b0;
            halted       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            clk_out      <= clk_out_d;
            cpu_ce       <= cpu_ce_d;
            div_ack      <= div_ack_d;
            halted       <= halted_d;
        end
    end

endmodule

// File: tb/tb_clk_run_ctrl.sv
// Scoreboard bench for clk_run_ctrl: a period-position reference model
// predicts every cycle's outputs; a monitor compares them against the DUT.
module tb_clk_run_ctrl;

    localparam int unsigned DIV_W = 16;
    localparam int          DEF_H = 10;

    logic             clk_in;
    logic             rst;
    logic             run_en;
    logic             step_req;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             div_ack;
    logic             clk_out;
    logic             cpu_ce;
    logic             halted;

    clk_run_ctrl #(
        .DIV_W        (DIV_W),
        .DEFAULT_HALF (DEF_H)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .run_en   (run_en),
        .step_req (step_req),
        .div_val  (div_val),
        .div_load (div_load),
        .div_ack  (div_ack),
        .clk_out  (clk_out),
        .cpu_ce   (cpu_ce),
        .halted   (halted)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0]  v;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned cyc_n  = 0;

    // Reference model: a period is tracked as a position 0..2h-1 since its rise.
    bit m_active, m_pend_valid, m_step_prev;
    int m_pos, m_h, m_pend;
    bit m_clk, m_ce, m_ack, m_halted;

    function automatic void model_step();
        bit edge_s, at_end;
        m_ce  = 1'b0;
        m_ack = 1'b0;
        if (rst) begin
            m_active     = 1'b0;
            m_pos        = 0;
            m_h          = DEF_H;
            m_pend_valid = 1'b0;
            m_step_prev  = 1'b0;
        end else begin
            edge_s      = step_req && !m_step_prev;
            m_step_prev = step_req;
            at_end      = m_active && (m_pos == 2 * m_h - 1);
            if (m_pend_valid && (!m_active || at_end)) begin
                m_h          = m_pend;
                m_ack        = 1'b1;
                m_pend_valid = 1'b0;
            end
            if (div_load) begin
                m_pend       = (div_val == 0) ? 1 : int'(div_val);
                m_pend_valid = 1'b1;
            end
            if (!m_active) begin
                if (run_en || edge_s) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                    m_ce     = 1'b1;
                end
            end else if (at_end) begin
                if (run_en) begin
                    m_pos = 0;
                    m_ce  = 1'b1;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_pos++;
            end
        end
        m_clk    = m_active && (m_pos < m_h);
        m_halted = !m_active;
    endfunction

    task automatic tick();
        exp_t e;
        model_step();
        e.v   = {m_clk, m_ce, m_ack, m_halted};
        e.cyc = cyc_n;
        exp_q.push_back(e);
        cyc_n++;
        @(negedge clk_in);
    endtask

    task automatic wait_pos(input int p, input int limit);
        int n;
        n = 0;
        while (!(m_active && m_pos == p) && n < limit) begin
            tick();
            n++;
        end
        if (!(m_active && m_pos == p)) begin
            checks++;
            $display("FAIL wait_pos: model position %0d not reached within %0d cycles (at %0d)", p, limit, m_pos);
        end
    endtask

    initial begin : monitor
        exp_t       e;
        logic [3:0] act;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {clk_out, cpu_ce, div_ack, halted};
                checks++;
                if (act === e.v) begin
                    passes++;
                end else begin
                    $display("FAIL cycle %0d {clk_out,cpu_ce,div_ack,halted}: got %b want %b", e.cyc, act, e.v);
                end
            end
        end
    end

    initial begin : stimulus
        rst      = 1'b1;
        run_en   = 1'b0;
        step_req = 1'b0;
        div_val  = '0;
        div_load = 1'b0;
        @(negedge clk_in);
        repeat (3) tick();
        rst = 1'b0;
        repeat (50) tick();

        run_en = 1'b1;
        repeat (70) tick();
        wait_pos(2, 40);
        run_en = 1'b0;
        repeat (25) tick();

        for (int k = 0; k < 2; k++) begin
            step_req = 1'b1;
            repeat (5) tick();
            step_req = 1'b0;
            repeat (30) tick();
        end

        run_en = 1'b1;
        wait_pos(5, 40);
        div_val  = 16'd4;
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        repeat (40) tick();

        div_val  = 16'd0;
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        repeat (20) tick();

        wait_pos(0, 10);
        div_val  = 16'd5;
        div_load = 1'b1;
        tick();
        div_val = 16'd6;
        tick();
        div_load = 1'b0;
        repeat (40) tick();

        wait_pos(2, 40);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        run_en = 1'b0;
        repeat (10) tick();

        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 39) == 0) run_en = ~run_en;
            if ($urandom_range(0, 9) == 0) step_req = ~step_req;
            div_load = ($urandom_range(0, 49) == 0);
            div_val  = 16'($urandom_range(0, 6));
            tick();
        end
        rst      = 1'b0;
        run_en   = 1'b0;
        div_load = 1'b0;
        repeat (5) tick();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk_in);
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/clk_run_ctrl.md
Name: clk_run_ctrl

Overview:
- Run/halt/single-step controller for the CPU clock domain on the FPGA build.
- Generates a programmable divided clock (clk_out, 50% duty) plus a one-cycle-per-period clock enable (cpu_ce) from clk_in.
- Supports free-run, halt, single-step for debug, and runtime divisor reconfiguration with an ack handshake.
- Never truncates a clk_out high or low phase.

Parameters:
- DIV_W, 16, width of the half-period divisor.
- DEFAULT_HALF, 10, half-period in clk_in cycles after reset (full period 20 cycles).

Ports:
- clk_in  input  1  system clock; all logic on its posedge.
- rst  input  1  synchronous reset, active-high.
- run_en  input  1  level; 1 = free-run, 0 = halt at the next period boundary.
- step_req  input  1  level from a debounced button; its rising edge requests one period.
- div_val  input  DIV_W  requested half-period in clk_in cycles.
- div_load  input  1  one-cycle pulse; captures div_val.
- div_ack  output  1  one-cycle pulse when a captured divisor becomes active.
- clk_out  output  1  divided clock (registered).
- cpu_ce  output  1  one-cycle pulse, asserted in the cycle clk_out goes 0->1.
- halted  output  1  1 when in HALT.

Behaviour:
- Reset: all outputs and state registers are registered and take these values.
  - state=HALT, cnt=0, half=DEFAULT_HALF, pend_valid=0.
  - clk_out=0, cpu_ce=0, div_ack=0, halted=1.
  - Reset mid-operation takes effect at the next edge; any partial period is abandoned.
- Period definition:
  - Rise edge sets clk_out=1, cpu_ce=1 for that cycle, cnt=0.
  - clk_out stays high for `half` cycles, then low for `half` cycles; cnt counts 0..half-1 within each phase.
  - The boundary is the last cycle of the low phase (cnt==half-1 with clk_out==0).
- States: HALT, RUN, FINISH.
  - HALT: cnt held 0, clk_out=0, cpu_ce=0.
    - run_en=1 -> RUN, rising on that edge.
    - Else a step_req rising edge -> FINISH, rising on that edge.
  - RUN: free-running periods.
    - run_en=0 at any cycle -> FINISH; the current period completes.
    - Otherwise, at the boundary, issue the next rise.
  - FINISH: completes the current period.
    - At the boundary: run_en=1 -> RUN with the next rise; else -> HALT, clk_out stays 0.
    - run_en reasserted mid-period -> RUN immediately, with no glitch.
- step_req edges in RUN or FINISH are ignored, not queued. step_req and run_en both active in HALT: run_en wins.
- Divisor handshake:
  - div_load captures div_val into the pending register and sets pend_valid. A div_val of 0 is clamped to 1.
  - A div_load while pend_valid=1 overwrites the pending value; only one ack is issued.
  - Pending is applied to `half` at the next boundary, or on the next cycle if in HALT. div_ack pulses in the apply cycle and pend_valid clears.
  - A div_load in the same cycle as a boundary is not applied at that boundary; it applies at the following one.
- Width rules:
  - cnt and half are DIV_W bits; no wrap is possible because cnt < half always holds.
  - half=1 gives period 2: clk_out toggles every cycle and cpu_ce fires every 2 cycles.
- Latency: run_en rising in HALT -> clk_out=1 and cpu_ce=1 on the next edge (1 cycle).

Decomposition:
- Shared package clk_ctrl_pkg:
  - state encoding (HALT=2'd0, RUN=2'd1, FINISH=2'd2);
  - DEFAULT_HALF;
  - DIV_W default.
- One sub-module, step_edge_det: registered rising-edge detector for step_req, producing a one-cycle step pulse.
- Everything else lives in clk_run_ctrl.

Test Plan:
- Reset then idle 50 cycles -> halted=1, clk_out=0, cpu_ce=0 throughout, div_ack never pulses.
- run_en=1 held, default half=10 -> cpu_ce every 20 cycles, clk_out high 10 / low 10, first rise 1 cycle after run_en.
- In HALT, pulse step_req high for 5 cycles -> exactly one cpu_ce and one 20-cycle clk_out period, then halted=1; a second edge gives exactly one more.
- While RUN, drop run_en 3 cycles into the high phase -> the period completes (7 more high, 10 low), then HALT with no further cpu_ce.
- div_val=4 with div_load mid-period in RUN:
  - current period stays 20 cycles;
  - div_ack pulses at the boundary;
  - subsequent cpu_ce every 8 cycles.
- Divisor edge cases and reset:
  - div_val=0 loaded -> period 2;
  - two div_loads (5 then 6) before a boundary -> single ack, half=6;
  - rst asserted mid-high-phase -> all reset values on the next edge.
